// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the requester handshake and the RAM-side bus of mem_arbiter.
//   slave  modport : the arbiter's view (takes requests, drives grants and the RAM bus)
//   master modport : the requesters' and RAM's view (the opposite directions)
// Signals:
//   enable       : high = new grants allowed, low = arbitration stalled
//   req          : level request per requester (4)
//   req_we       : per-requester write flag, valid while req[i]
//   req_address  : slot i at [i*ADDRESS_BITS +: ADDRESS_BITS]
//   req_data     : slot i at [i*DATA_BITS +: DATA_BITS]
//   gnt          : one-hot or zero, combinational
//   rvalid       : one-hot or zero, read data valid for requester i
//   rdata        : read data, equals ram_data_out
//   ram_address  : registered RAM address
//   ram_w_enable : registered RAM write enable
//   ram_data_in  : registered RAM write data
//   ram_data_out : RAM read data, valid one clock after the address
//
// Handshake: an access from requester i is accepted at the rising edge
// where req[i] & gnt[i]; the requester may then change address/data or
// keep req high to ask for another access.
interface mem_arbiter_if #(
    parameter int ADDRESS_BITS = 5,
    parameter int DATA_BITS    = 8
);
    logic                      enable;
    logic [3:0]                req;
    logic [3:0]                req_we;
    logic [4*ADDRESS_BITS-1:0] req_address;
    logic [4*DATA_BITS-1:0]    req_data;
    logic [3:0]                gnt;
    logic [3:0]                rvalid;
    logic [DATA_BITS-1:0]      rdata;
    logic [ADDRESS_BITS-1:0]   ram_address;
    logic                      ram_w_enable;
    logic [DATA_BITS-1:0]      ram_data_in;
    logic [DATA_BITS-1:0]      ram_data_out;

    modport slave (
        input  enable, req, req_we, req_address, req_data, ram_data_out,
        output gnt, rvalid, rdata, ram_address, ram_w_enable, ram_data_in
    );

    modport master (
        output enable, req, req_we, req_address, req_data, ram_data_out,
        input  gnt, rvalid, rdata, ram_address, ram_w_enable, ram_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter and access sequencer in front of a single-port RAM.
// Four requesters share the RAM; one access is accepted per cycle. The RAM
// address, write enable and write data are registered; read data returns to
// the winning requester two edges after accept with a one-cycle rvalid pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (requests, grants, read return, RAM bus)
module mem_arbiter #(
    parameter int ADDRESS_BITS = 5,
    parameter int DATA_BITS    = 8
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.slave     bus
);
    logic [1:0]              ptr;
    logic [1:0]              winner;
    logic [1:0]              idx;
    logic                    found;
    logic [3:0]              gnt_c;
    logic                    accept;

    logic [ADDRESS_BITS-1:0] address_q;
    logic [DATA_BITS-1:0]    data_in_q;
    logic                    w_enable_q;

    // Read-return tags: stage 1 covers the cycle the RAM sees the address,
    // stage 2 the cycle its registered read data is on ram_data_out.
    logic                    s1_valid;
    logic [1:0]              s1_id;
    logic                    s2_valid;
    logic [1:0]              s2_id;

    // Search p, p+1, p+2, p+3 (2-bit wrap); first active request wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        gnt_c  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (found && bus.enable && !reset) begin
            gnt_c[winner] = 1'b1;
        end
    end

    // gnt only ever selects an active requester, so any grant is an accept.
    assign accept  = |gnt_c;
    assign bus.gnt = gnt_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= 2'd0;
            address_q  <= '0;
            data_in_q  <= '0;
            w_enable_q <= 1'b0;
            s1_valid   <= 1'b0;
            s1_id      <= 2'd0;
            s2_valid   <= 1'b0;
            s2_id      <= 2'd0;
        end else begin
            // Stage 2 advances regardless of enable so in-flight reads return.
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            if (accept) begin
                address_q  <= bus.req_address[winner*ADDRESS_BITS +: ADDRESS_BITS];
                data_in_q  <= bus.req_data[winner*DATA_BITS +: DATA_BITS];
                w_enable_q <= bus.req_we[winner];
                ptr        <= winner + 2'd1;
                s1_valid   <= ~bus.req_we[winner];
                s1_id      <= winner;
            end else begin
                // Address and data hold; only the strobe and tag drop.
                w_enable_q <= 1'b0;
                s1_valid   <= 1'b0;
            end
        end
    end

    assign bus.ram_address  = address_q;
    assign bus.ram_data_in  = data_in_q;
    assign bus.ram_w_enable = w_enable_q;
    assign bus.rvalid       = s2_valid ? (4'b0001 << s2_id) : 4'b0000;
    assign bus.rdata        = bus.ram_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives mem_arbiter through directed scenarios (reset, single read, full
// contention, write-then-read, stall, reset mid-flight) and a randomized
// phase, checking every cycle against a behavioural model: a shadow memory,
// a round-robin pointer and a two-deep queue of expected read returns.
module tb_mem_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic clk;
    logic reset;

    mem_arbiter_if #(.ADDRESS_BITS(AW), .DATA_BITS(DW)) bus ();

    mem_arbiter #(.ADDRESS_BITS(AW), .DATA_BITS(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM substrate ----------------
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_w_enable) ram_mem[bus.ram_address] <= bus.ram_data_in;
        bus.ram_data_out <= ram_mem[bus.ram_address];
    end

    // ---------------- reference model ----------------
    logic [DW-1:0]    model_mem [0:(1<<AW)-1];
    int               m_ptr;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_din;
    logic             m_we;
    // Each entry: {rvalid[3:0], rdata[DW-1:0]} expected in a future cycle.
    logic [4+DW-1:0]  exp_q[$];

    int n_checks;
    int n_fail;
    int cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic set_slot(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_we[i]                 = we;
        bus.req_address[i*AW +: AW]   = a;
        bus.req_data[i*DW +: DW]      = d;
    endtask

    task automatic idle_inputs();
        bus.req         = 4'b0000;
        bus.req_we      = 4'b0000;
        bus.req_address = '0;
        bus.req_data    = '0;
        bus.enable      = 1'b1;
        reset           = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        int            win;
        logic [3:0]    eg;
        logic [4+DW-1:0] head;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        win = -1;
        if (!reset && bus.enable) begin
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && bus.req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
            end
        end
        eg = (win >= 0) ? (4'b0001 << win) : 4'b0000;
        check("gnt", {28'd0, bus.gnt}, {28'd0, eg});
        head = exp_q.pop_front();
        check("rvalid", {28'd0, bus.rvalid}, {28'd0, head[4+DW-1:DW]});
        if (head[4+DW-1:DW] != 4'b0000)
            check("rdata", {24'd0, bus.rdata}, {24'd0, head[DW-1:0]});
        check("ram_address", {27'd0, bus.ram_address}, {27'd0, m_addr});
        check("ram_w_enable", {31'd0, bus.ram_w_enable}, {31'd0, m_we});
        check("ram_data_in", {24'd0, bus.ram_data_in}, {24'd0, m_din});
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
            m_ptr  = 0;
            m_addr = '0;
            m_din  = '0;
            m_we   = 1'b0;
        end else if (win >= 0) begin
            a      = bus.req_address[win*AW +: AW];
            d      = bus.req_data[win*DW +: DW];
            m_addr = a;
            m_din  = d;
            m_we   = bus.req_we[win];
            m_ptr  = (win + 1) % 4;
            if (bus.req_we[win]) begin
                model_mem[a] = d;
                exp_q.push_back('0);
            end else begin
                exp_q.push_back({eg, model_mem[a]});
            end
        end else begin
            m_we = 1'b0;
            exp_q.push_back('0);
        end
        cyc++;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int i = 0; i < (1<<AW); i++) begin
            ram_mem[i]   = DW'(i + 10);
            model_mem[i] = DW'(i + 10);
        end
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        m_ptr = 0; m_addr = '0; m_din = '0; m_we = 1'b0;

        // Reset held with all requesters active: no grants.
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) set_slot(i, 1'b0, AW'(i), 8'h00);
        reset = 1'b1;
        repeat (2) tick();
        // First grant after release goes to requester 0; then drain.
        idle_inputs();
        bus.req = 4'b0001;
        set_slot(0, 1'b0, 5'd2, 8'h00);
        tick();
        bus.req = 4'b0000;
        repeat (3) tick();

        // Full contention: order 0,1,2,3 repeating.
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) set_slot(i, 1'b0, AW'(i), 8'h00);
        repeat (8) tick();
        bus.req = 4'b0000;
        repeat (3) tick();

        // Write 0xAB to address 5 from requester 1, then read it from requester 0.
        bus.req = 4'b0010;
        set_slot(1, 1'b1, 5'd5, 8'hAB);
        tick();
        bus.req = 4'b0001;
        set_slot(0, 1'b0, 5'd5, 8'h00);
        tick();
        bus.req = 4'b0000;
        repeat (3) tick();

        // Stall with a read in flight; pointer must survive.
        bus.req = 4'b0001;
        set_slot(0, 1'b0, 5'd3, 8'h00);
        tick();
        bus.enable = 1'b0;
        bus.req    = 4'b0110;
        set_slot(1, 1'b0, 5'd1, 8'h00);
        set_slot(2, 1'b0, 5'd2, 8'h00);
        repeat (3) tick();
        bus.enable = 1'b1;
        repeat (2) tick();
        bus.req = 4'b0000;
        repeat (3) tick();

        // Reset mid-flight: read accepted, then reset at the following edge.
        bus.req = 4'b0100;
        set_slot(2, 1'b0, 5'd7, 8'h00);
        tick();
        bus.req = 4'b0000;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 4'b1000;
        set_slot(3, 1'b0, 5'd4, 8'h00);
        tick();
        bus.req = 4'b0000;
        repeat (4) tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 99) < 2);
            bus.enable = ($urandom_range(0, 9) != 0);
            bus.req    = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++)
                set_slot(i, ($urandom_range(0, 3) == 0), AW'($urandom_range(0, (1<<AW)-1)),
                         DW'($urandom_range(0, 255)));
            tick();
        end
        idle_inputs();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
